// File: rtl/sys_arr_collector_pkg.sv
// Shared widths and row classification for the systolic-array result collector.
package sys_arr_collector_pkg;

   localparam int unsigned SUM_WIDTH    = 16;
   localparam int unsigned DATA_WIDTH   = 8;
   localparam int unsigned WEIGHT_WIDTH = 8;
   localparam int unsigned COUNT_WIDTH  = 16;

   typedef enum logic [1:0] {
      ROW_IDLE,
      ROW_COMPLETE,
      ROW_MALFORMED
   } row_class_e;

endpackage

// File: rtl/sys_arr_result_fifo.sv
// Synchronous FIFO for aligned result rows; rdata is the registered head entry, zero when empty.
module sys_arr_result_fifo #(
   parameter int unsigned width = 64,
   parameter int unsigned depth = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [width-1:0] wdata,
   output logic [width-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (depth > 1) ? $clog2(depth) : 1;
   localparam int unsigned CW = $clog2(depth) + 1;

   logic [width-1:0] mem_q [depth];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             wr_en, rd_en;

   assign full  = (count_q == CW'(depth));
   assign empty = (count_q == '0);
   // A push into a full FIFO is only accepted when the head leaves on the same edge.
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign rdata = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/sys_arr_collector.sv
// Deskews per-column systolic-array sums into aligned rows, buffers them and hands them downstream.
module sys_arr_collector
   import sys_arr_collector_pkg::*;
#(
   parameter int unsigned width_height = 4,
   parameter int unsigned fifo_depth   = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [SUM_WIDTH*width_height-1:0] maccout,
   input  logic [width_height-1:0]           activeout,
   output logic [SUM_WIDTH*width_height-1:0] rowout,
   output logic                              rowvalid,
   input  logic                              rowready,
   output logic [COUNT_WIDTH-1:0]            rowcount,
   output logic                              overflow,
   output logic                              skew_err,
   input  logic                              clear_flags
);

   localparam int unsigned ROW_W = SUM_WIDTH * width_height;

   logic [ROW_W-1:0]        aligned_row;
   logic [width_height-1:0] aligned_vld;

   // Column c arrives c cycles after column 0, so it is delayed by the remaining columns.
   for (genvar c = 0; c < width_height; c++) begin : g_col
      localparam int unsigned STAGES = width_height - 1 - c;
      if (STAGES == 0) begin : g_pass
         assign aligned_row[c*SUM_WIDTH +: SUM_WIDTH] = maccout[c*SUM_WIDTH +: SUM_WIDTH];
         assign aligned_vld[c]                        = activeout[c];
      end else begin : g_dly
         logic [SUM_WIDTH-1:0] sum_q [STAGES];
         logic [STAGES-1:0]    vld_q;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               sum_q <= '{default: '0};
               vld_q <= '0;
            end else begin
               sum_q[0] <= maccout[c*SUM_WIDTH +: SUM_WIDTH];
               vld_q[0] <= activeout[c];
               for (int unsigned s = 1; s < STAGES; s++) begin
                  sum_q[s] <= sum_q[s-1];
                  vld_q[s] <= vld_q[s-1];
               end
            end
         end
         assign aligned_row[c*SUM_WIDTH +: SUM_WIDTH] = sum_q[STAGES-1];
         assign aligned_vld[c]                        = vld_q[STAGES-1];
      end
   end

   row_class_e             row_class;
   logic                   fifo_full, fifo_empty;
   logic                   push, pop, drop;
   logic [COUNT_WIDTH-1:0] rowcount_q, rowcount_d;
   logic                   overflow_q, overflow_d;
   logic                   skew_err_q, skew_err_d;

   always_comb begin
      row_class = ROW_IDLE;
      if (&aligned_vld)      row_class = ROW_COMPLETE;
      else if (|aligned_vld) row_class = ROW_MALFORMED;
   end

   assign pop  = !fifo_empty && rowready;
   assign push = (row_class == ROW_COMPLETE) && (!fifo_full || pop);
   assign drop = (row_class == ROW_COMPLETE) && fifo_full && !pop;

   // A set condition in the same cycle as clear_flags wins.
   always_comb begin
      rowcount_d = rowcount_q;
      if (push) rowcount_d = rowcount_q + 1'b1;
      overflow_d = (overflow_q && !clear_flags) || drop;
      skew_err_d = (skew_err_q && !clear_flags) || (row_class == ROW_MALFORMED);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rowcount_q <= '0;
         overflow_q <= 1'b0;
         skew_err_q <= 1'b0;
      end else begin
         rowcount_q <= rowcount_d;
         overflow_q <= overflow_d;
         skew_err_q <= skew_err_d;
      end
   end

   sys_arr_result_fifo #(
      .width (ROW_W),
      .depth (fifo_depth)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (aligned_row),
      .rdata (rowout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign rowvalid = !fifo_empty;
   assign rowcount = rowcount_q;
   assign overflow = overflow_q;
   assign skew_err = skew_err_q;

endmodule

// File: tb/tb_sys_arr_collector.sv
// Directed bench for sys_arr_collector: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_sys_arr_collector;

   localparam int W = 4;
   localparam int D = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] maccout = '0;
   logic [3:0]  activeout = '0;
   logic [63:0] rowout;
   logic        rowvalid;
   logic        rowready = 1'b0;
   logic [15:0] rowcount;
   logic        overflow;
   logic        skew_err;
   logic        clear_flags = 1'b0;

   sys_arr_collector #(
      .width_height (W),
      .fifo_depth   (D)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .maccout     (maccout),
      .activeout   (activeout),
      .rowout      (rowout),
      .rowvalid    (rowvalid),
      .rowready    (rowready),
      .rowcount    (rowcount),
      .overflow    (overflow),
      .skew_err    (skew_err),
      .clear_flags (clear_flags)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int pops     = 0;
   int run      = 0;
   int max_run  = 0;
   bit mon_en   = 1'b0;
   logic [63:0] exp_q [$];

   typedef struct {
      logic [3:0]  act;
      logic [63:0] sums;
      logic        rdy;
      logic        clr;
      logic        exp_v;
      logic [63:0] exp_row;
      logic [15:0] exp_cnt;
      logic        exp_ovf;
      logic        exp_skew;
   } vec_t;

   localparam int NV = 12;
   vec_t tbl [NV];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", nm, got, exp);
      end
   endtask

   function automatic logic [63:0] mkrow(input int k);
      logic [63:0] r;
      r = '0;
      for (int c = 0; c < W; c++) r[c*16 +: 16] = 16'(k * 16 + c);
      return r;
   endfunction

   // Scoreboard: every accepted row must match the oldest expected row.
   always @(negedge clk) begin
      if (mon_en) begin
         if (rowvalid) begin
            run++;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
         if (rowvalid && rowready) begin
            pops++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_row: got %h, required none", rowout);
            end else begin
               chk("pop_order", rowout, exp_q.pop_front());
            end
         end
      end
   end

   task automatic reset_dut();
      reset       = 1'b1;
      activeout   = '0;
      maccout     = '0;
      clear_flags = 1'b0;
      rowready    = 1'b0;
      exp_q.delete();
      run = 0;
      max_run = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic idle(input int n);
      activeout = '0;
      maccout   = '0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives n rows skewed one cycle per column; row r column c goes out in cycle r+c.
   task automatic send_rows(input int n, input int base, input int ready_cycle);
      logic [63:0] row;
      for (int i = 0; i < n + W - 1; i++) begin
         activeout = '0;
         maccout   = '0;
         for (int c = 0; c < W; c++) begin
            if (i - c >= 0 && i - c < n) begin
               row = mkrow(base + i - c);
               activeout[c] = 1'b1;
               maccout[c*16 +: 16] = row[c*16 +: 16];
            end
         end
         if (ready_cycle >= 0) rowready = (i == ready_cycle);
         @(posedge clk);
         #1;
      end
      activeout = '0;
      maccout   = '0;
      if (ready_cycle >= 0) rowready = 1'b0;
   endtask

   task automatic drain(input string nm);
      rowready = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      chk(nm, 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
      chk({nm, "_valid_low"}, 64'(rowvalid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;

      // Single row (cycles 0..4), then column 2 one cycle late (5..11).
      tbl[0]  = '{4'b0001, 64'h0000_0000_0000_000A, 1, 0, 0, 64'h0, 16'd0, 0, 0};
      tbl[1]  = '{4'b0010, 64'h0000_0000_0014_0000, 1, 0, 0, 64'h0, 16'd0, 0, 0};
      tbl[2]  = '{4'b0100, 64'h0000_001E_0000_0000, 1, 0, 0, 64'h0, 16'd0, 0, 0};
      tbl[3]  = '{4'b1000, 64'h0028_0000_0000_0000, 1, 0, 1, 64'h0028_001E_0014_000A, 16'd1, 0, 0};
      tbl[4]  = '{4'b0000, 64'h0,                   1, 0, 0, 64'h0, 16'd1, 0, 0};
      tbl[5]  = '{4'b0001, 64'h0000_0000_0000_1111, 1, 0, 0, 64'h0, 16'd1, 0, 0};
      tbl[6]  = '{4'b0010, 64'h0000_0000_2222_0000, 1, 0, 0, 64'h0, 16'd1, 0, 0};
      tbl[7]  = '{4'b0000, 64'h0,                   1, 0, 0, 64'h0, 16'd1, 0, 0};
      tbl[8]  = '{4'b1100, 64'h4444_3333_0000_0000, 1, 0, 0, 64'h0, 16'd1, 0, 1};
      tbl[9]  = '{4'b0000, 64'h0,                   1, 1, 0, 64'h0, 16'd1, 0, 1};
      tbl[10] = '{4'b0000, 64'h0,                   1, 1, 0, 64'h0, 16'd1, 0, 0};
      tbl[11] = '{4'b0000, 64'h0,                   1, 0, 0, 64'h0, 16'd1, 0, 0};

      reset_dut();
      chk("rst_rowvalid", 64'(rowvalid), 64'd0);
      chk("rst_rowout",   rowout,        64'd0);
      chk("rst_rowcount", 64'(rowcount), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_skew_err", 64'(skew_err), 64'd0);

      for (int i = 0; i < NV; i++) begin
         activeout   = tbl[i].act;
         maccout     = tbl[i].sums;
         rowready    = tbl[i].rdy;
         clear_flags = tbl[i].clr;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_rowvalid", i), 64'(rowvalid), 64'(tbl[i].exp_v));
         chk($sformatf("vec%0d_rowout", i),   rowout,        tbl[i].exp_row);
         chk($sformatf("vec%0d_rowcount", i), 64'(rowcount), 64'(tbl[i].exp_cnt));
         chk($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(tbl[i].exp_ovf));
         chk($sformatf("vec%0d_skew_err", i), 64'(skew_err), 64'(tbl[i].exp_skew));
      end
      clear_flags = 1'b0;

      mon_en = 1'b1;

      // Back-to-back rows with rowready held high.
      reset_dut();
      rowready = 1'b1;
      for (int k = 0; k < 4; k++) exp_q.push_back(mkrow(k));
      p0 = pops;
      send_rows(4, 0, -1);
      idle(3);
      chk("b2b_pops",     64'(pops - p0), 64'd4);
      chk("b2b_run",      64'(max_run),   64'd4);
      chk("b2b_rowcount", 64'(rowcount),  64'd4);
      chk("b2b_left",     64'(exp_q.size()), 64'd0);

      // Backpressure: nine rows into eight entries.
      reset_dut();
      for (int k = 0; k < 8; k++) exp_q.push_back(mkrow('h10 + k));
      send_rows(9, 'h10, -1);
      chk("ovf_overflow", 64'(overflow), 64'd1);
      chk("ovf_rowcount", 64'(rowcount), 64'd8);
      chk("ovf_rowvalid", 64'(rowvalid), 64'd1);
      chk("ovf_head",     rowout,        mkrow('h10));
      chk("ovf_skew_err", 64'(skew_err), 64'd0);
      p0 = pops;
      drain("ovf_drain");
      chk("ovf_pops", 64'(pops - p0), 64'd8);

      // Full FIFO with push and pop on the same edge.
      reset_dut();
      for (int k = 0; k < 8; k++) exp_q.push_back(mkrow('h20 + k));
      send_rows(8, 'h20, -1);
      chk("full_rowcount", 64'(rowcount), 64'd8);
      exp_q.push_back(mkrow('h28));
      send_rows(1, 'h28, W - 1);
      chk("fullpop_overflow", 64'(overflow), 64'd0);
      chk("fullpop_rowcount", 64'(rowcount), 64'd9);
      chk("fullpop_head",     rowout,        mkrow('h21));
      p0 = pops;
      drain("fullpop_drain");
      chk("fullpop_occupancy", 64'(pops - p0), 64'd8);

      // Asynchronous reset in the middle of a partially presented row.
      reset_dut();
      send_rows(1, 'h2F, -1);
      chk("mid_pre_rowvalid", 64'(rowvalid), 64'd1);
      activeout = 4'b0001;
      maccout   = 64'h0000_0000_0000_DEAD;
      @(posedge clk);
      #1;
      activeout = 4'b0010;
      maccout   = 64'h0000_0000_BEEF_0000;
      @(posedge clk);
      #1;
      activeout = '0;
      maccout   = '0;
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rowvalid", 64'(rowvalid), 64'd0);
      chk("mid_rowout",   rowout,        64'd0);
      chk("mid_rowcount", 64'(rowcount), 64'd0);
      chk("mid_overflow", 64'(overflow), 64'd0);
      chk("mid_skew_err", 64'(skew_err), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      rowready = 1'b1;
      exp_q.push_back(mkrow('h30));
      p0 = pops;
      send_rows(1, 'h30, -1);
      idle(3);
      chk("mid_post_pops",     64'(pops - p0),    64'd1);
      chk("mid_post_rowcount", 64'(rowcount),     64'd1);
      chk("mid_post_skew_err", 64'(skew_err),     64'd0);
      chk("mid_post_left",     64'(exp_q.size()), 64'd0);

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sys_arr_collector.md
Name: sys_arr_collector

Overview:
Receiving end of the systolic array output interface. Takes per-column MAC results (maccout) and per-column valid flags (activeout), which leave the array skewed by one cycle per column. Removes the skew so each result row is aligned, buffers aligned rows in a small FIFO, and presents them to the downstream result writer over a valid/ready handshake. Also detects malformed skew patterns and buffer overflow.

Parameters:
width_height, 4, array columns; one 16-bit sum per column
fifo_depth, 8, aligned-row FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
maccout  in  16*width_height  column sums; column c in bits [16c+15:16c]
activeout  in  width_height  bit c high = column c sum valid this cycle
rowout  out  16*width_height  head-of-FIFO aligned row, same column packing
rowvalid  out  1  rowout holds a valid row
rowready  in  1  downstream accepts the row; pop when rowvalid && rowready
rowcount  out  16  rows written into the FIFO since reset; wraps 0xFFFF -> 0
overflow  out  1  sticky: an aligned row was dropped because the FIFO was full
skew_err  out  1  sticky: a partially-valid aligned row was seen
clear_flags  in  1  synchronous clear of overflow and skew_err

Behaviour:
- Reset, async on reset high: all deskew registers and valid bits cleared, FIFO empty, rowvalid=0, rowout=0, rowcount=0, overflow=0, skew_err=0. In-flight partial rows are discarded.
- Deskew: column c passes through (width_height-1-c) register stages for both sum and valid. Column width_height-1 has zero stages.
- Alignment timing: a row whose column c is presented in cycle t+c is aligned in cycle t+width_height-1.
- Aligned-row classification, once per cycle:
  - All aligned valid bits = 1: complete row.
  - All = 0: idle; no action.
  - Any other mix: malformed. Row is dropped, skew_err set, rowcount unchanged.
- Push: a complete row is written at the edge ending cycle t+width_height-1. rowcount increments on that edge.
- FIFO read latency: registered, no bypass. With the FIFO empty, rowvalid rises in cycle t+width_height. Total latency from column 0 input to rowvalid = width_height cycles.
- Pop: when rowvalid && rowready, advance to the next entry. rowvalid falls if the FIFO becomes empty.
- rowout ordering: rowout is stable while rowvalid && !rowready. Rows leave in arrival order.
- FIFO full, push without pop: row dropped, overflow set, rowcount unchanged.
- FIFO full, push with pop in the same cycle: both occur, no overflow, occupancy unchanged.
- FIFO empty, push with rowready high: no pop that cycle (nothing valid), push occurs.
- Flag clear: clear_flags clears both flags on the next edge. If a set condition occurs in the same cycle, set wins.
- Arithmetic: sums pass through unmodified. No saturation, no sign handling.
- Throughput: one complete row per cycle, sustained while rowready is high.

Decomposition:
- Shared package constants: SUM_WIDTH=16, DATA_WIDTH=8, WEIGHT_WIDTH=8, matching the array's per-PE widths. Top-level widths derive from these times width_height.
- Sub-module sys_arr_result_fifo: synchronous FIFO with parameters width and depth. Ports: push, pop, wdata, rdata, full, empty.
- The deskew chain is a generate loop in the top module.

Test Plan:
1. Single row: present sums 0x000A, 0x0014, 0x001E, 0x0028 for columns 0..3 with activeout bits 0001 in cycle t, 0010 in t+1, 0100 in t+2, 1000 in t+3; rowready=1 -> rowvalid rises in cycle t+4 with rowout=0x0028_001E_0014_000A; rowcount=1; no flags set.
2. Back-to-back: 4 skewed rows with column sums row index*0x10 + column, so row k carries (k*0x10, k*0x10+1, k*0x10+2, k*0x10+3) in columns 0..3; rowready=1 -> rowvalid high for 4 consecutive cycles; rows emerge in order k=0..3; rowcount=4.
3. Backpressure/overflow: rowready=0, push 9 rows with fifo_depth=8 -> first 8 rows retained; overflow=1; rowcount=8. Then raise rowready -> rows 0..7 drain in order.
4. Full + simultaneous pop: fill the FIFO, then push one row in the same cycle as a pop -> overflow stays 0, occupancy stays 8, rowcount increments.
5. Skew error: column 2 valid one cycle late -> skew_err=1, no FIFO write. Pulse clear_flags -> skew_err=0 on the next edge.
6. Reset mid-row: assert reset after columns 0..1 of a row have been presented -> all outputs 0 immediately. After release, feed a full row -> exactly one row emerges, and none of the pre-reset columns appear in rowout.
